rc_mse_monitor: RTL and testbench

Streaming error-characterisation block for the 16-bit approximate ripple-carry adders. It accepts operand pairs together with the approximate adder's sum and recomputes the exact sum internally. It accumulates sample count, nonzero-error count, sum of squared error distance and maximum error distance, and returns a snapshot through a request/report handshake. It sits between the adder under evaluation and the MSE/area characterisation harness.

---
 rtl/rc_mse_monitor.sv | 178 +++++++++++++++++
 tb/tb_rc_mse_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rc_mse_monitor.sv
// rc_mse_monitor: streaming error statistics for an approximate WIDTH-bit adder.
// Recomputes the exact sum, pipelines |approx - exact| and its square, and
// accumulates sample count, nonzero-error count, squared-error sum and max error
// with saturating arithmetic. A RUN/DRAIN/REPORT FSM hands out stable snapshots.
module rc_mse_monitor #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    input  logic             clear,
    input  logic             rpt_req,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sq_err_sum,
    output logic [WIDTH:0]   max_err,
    output logic             sat
);

    localparam int DW  = WIDTH + 2;     // signed error distance width
    localparam int SQW = 2 * WIDTH + 2; // squared error width

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_REPORT} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             flush;

    // Stage 1: signed error distance
    logic             v1_q, v1_d;
    logic [DW-1:0]    d1_q, d1_d;
    logic [WIDTH:0]   exact;
    // Stage 2: magnitude, square, nonzero flag
    logic             v2_q, v2_d;
    logic [WIDTH:0]   m2_q, m2_d;
    logic [SQW-1:0]   sq2_q, sq2_d;
    logic             nz2_q, nz2_d;
    logic [SQW-1:0]   m_ext;
    // Stage 3: commit register feeding the accumulators
    logic             v3_q, v3_d;
    logic [WIDTH:0]   m3_q, m3_d;
    logic [SQW-1:0]   sq3_q, sq3_d;
    logic             nz3_q, nz3_d;
    // Accumulators
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] sq_err_q, sq_err_d;
    logic [WIDTH:0]   max_err_q, max_err_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   sq_wide;

    // FSM next state and handshake outputs; DRAIN may leave while stage 3 commits
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        rpt_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready = 1'b1;
                if (rpt_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!v1_q && !v2_q) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                rpt_valid = 1'b1;
                if (rpt_ready) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Transfer qualification; clear is honoured everywhere except REPORT
    always_comb begin
        accept = in_valid && in_ready;
        flush  = clear && (state_q != ST_REPORT);
    end

    // Datapath stages; a flush drops every in-flight sample including the one arriving
    always_comb begin
        exact = {1'b0, in_a} + {1'b0, in_b};
        d1_d  = {1'b0, in_approx} - {1'b0, exact};
        v1_d  = accept && !flush;

        m2_d  = d1_q[DW-1] ? (WIDTH+1)'(-d1_q) : d1_q[WIDTH:0];
        m_ext = SQW'(m2_d);
        sq2_d = m_ext * m_ext;
        nz2_d = (m2_d != '0);
        v2_d  = v1_q && !flush;

        m3_d  = m2_q;
        sq3_d = sq2_q;
        nz3_d = nz2_q;
        v3_d  = v2_q && !flush;
    end

    // Saturating accumulation of the committed stage-3 sample
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sq_err_d     = sq_err_q;
        max_err_d    = max_err_q;
        sat_d        = sat_q;
        sq_wide      = {1'b0, sq_err_q} + (ACC_W+1)'(sq3_q);
        if (flush) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sq_err_d     = '0;
            max_err_d    = '0;
            sat_d        = 1'b0;
        end else if (v3_q) begin
            if (sample_cnt_q == '1) sat_d = 1'b1;
            else                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (nz3_q) begin
                if (err_cnt_q == '1) sat_d = 1'b1;
                else                 err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (sq_wide[ACC_W]) begin
                sq_err_d = '1;
                sat_d    = 1'b1;
            end else begin
                sq_err_d = sq_wide[ACC_W-1:0];
            end
            if (m3_q > max_err_q) max_err_d = m3_q;
        end
    end

    // Control and statistics registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sq_err_q     <= '0;
            max_err_q    <= '0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v3_q         <= v3_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sq_err_q     <= sq_err_d;
            max_err_q    <= max_err_d;
            sat_q        <= sat_d;
        end
    end

    // Datapath payload registers; qualified by the valid bits, so no reset needed
    always_ff @(posedge clk) begin
        d1_q  <= d1_d;
        m2_q  <= m2_d;
        sq2_q <= sq2_d;
        nz2_q <= nz2_d;
        m3_q  <= m3_d;
        sq3_q <= sq3_d;
        nz3_q <= nz3_d;
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sq_err_sum = sq_err_q;
    assign max_err    = max_err_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_rc_mse_monitor.sv
// Directed testbench for rc_mse_monitor: a default build plus a CNT_W=2 build
// sharing the same stimulus, checked against hand-computed values.
module tb_rc_mse_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [16:0] in_approx;
    logic        clear;
    logic        rpt_req;
    logic        rpt_ready;

    logic        in_ready, rpt_valid, sat;
    logic [31:0] sample_cnt, err_cnt;
    logic [47:0] sq_err_sum;
    logic [16:0] max_err;

    logic        s_in_ready, s_rpt_valid, s_sat;
    logic [1:0]  s_sample_cnt, s_err_cnt;
    logic [47:0] s_sq_err_sum;
    logic [16:0] s_max_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rc_mse_monitor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .clear(clear),
        .rpt_req(rpt_req), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sq_err_sum(sq_err_sum),
        .max_err(max_err), .sat(sat)
    );

    rc_mse_monitor #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .clear(clear),
        .rpt_req(rpt_req), .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
        .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sq_err_sum(s_sq_err_sum),
        .max_err(s_max_err), .sat(s_sat)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        step();
        in_valid  = 1'b0;
        $display("send a=0x%0h b=0x%0h approx=0x%0h", a, b, ap);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Waits for rpt_valid after the rpt_req edge; latency bound is 4 edges
    task automatic wait_report(input string tag);
        int cyc = 0;
        while (!rpt_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check_eq({tag, "_rpt_valid"}, 64'(rpt_valid), 64'd1);
        check_eq({tag, "_latency_ok"}, 64'(cyc <= 3), 64'd1);
    endtask

    task automatic request_report(input string tag);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        wait_report(tag);
    endtask

    task automatic finish_report(input string tag);
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        check_eq({tag, "_rpt_valid_low"}, 64'(rpt_valid), 64'd0);
        check_eq({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_stats(input string tag, input logic [31:0] sc, input logic [31:0] ec,
                               input logic [47:0] sq, input logic [16:0] mx, input logic st);
        check_eq({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(sc));
        check_eq({tag, "_err_cnt"},    64'(err_cnt),    64'(ec));
        check_eq({tag, "_sq_err_sum"}, 64'(sq_err_sum), 64'(sq));
        check_eq({tag, "_max_err"},    64'(max_err),    64'(mx));
        check_eq({tag, "_sat"},        64'(sat),        64'(st));
        $display("%s: cnt=%0d err=%0d sq=%0d max=%0d sat=%0d", tag,
                 sample_cnt, err_cnt, sq_err_sum, max_err, sat);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
        clear = 1'b0; rpt_req = 1'b0; rpt_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_rpt_valid", 64'(rpt_valid), 64'd0);
        check_stats("reset", 32'd0, 32'd0, 48'd0, 17'd0, 1'b0);

        // rpt_ready while idle must not disturb RUN
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        check_eq("idle_rpt_ready_in_ready", 64'(in_ready), 64'd1);
        check_eq("idle_rpt_ready_rpt_valid", 64'(rpt_valid), 64'd0);

        // Exact samples
        send(16'd3, 16'd5, 17'd8);
        send(16'hFFFF, 16'h0001, 17'h10000);
        request_report("exact");
        check_stats("exact", 32'd2, 32'd0, 48'd0, 17'd0, 1'b0);
        finish_report("exact");
        pulse_clear();

        // Signed errors: +1 and -256
        send(16'd1, 16'd1, 17'd3);
        send(16'h00FF, 16'h0001, 17'h00000);
        request_report("signed");
        check_stats("signed", 32'd2, 32'd2, 48'd65537, 17'd256, 1'b0);
        finish_report("signed");
        pulse_clear();

        // Back-to-back stream with rpt_req on the 10th transfer
        in_a = 16'd0; in_b = 16'd0; in_approx = 17'h10000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) rpt_req = 1'b1;
            step();
        end
        rpt_req = 1'b0;
        check_eq("b2b_in_ready_drop", 64'(in_ready), 64'd0);
        // keep offering an erroneous sample that must not be accepted
        in_approx = 17'h00005;
        wait_report("b2b");
        check_stats("b2b", 32'd10, 32'd10, 48'hA_0000_0000, 17'h10000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_rpt_valid", 64'(rpt_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("hold_sample_cnt", 64'(sample_cnt), 64'd10);
            check_eq("hold_sq_err_sum", 64'(sq_err_sum), 64'hA_0000_0000);
        end
        in_valid = 1'b0;
        finish_report("b2b");
        check_eq("b2b_after_sample_cnt", 64'(sample_cnt), 64'd10);

        // Clear with coincident transfer; also pins the 3-edge latency
        pulse_clear();
        check_stats("clear0", 32'd0, 32'd0, 48'd0, 17'd0, 1'b0);
        send(16'd1, 16'd1, 17'd3);
        step(); step();
        check_eq("latency_edge2", 64'(sample_cnt), 64'd0);
        step();
        check_eq("latency_edge3", 64'(sample_cnt), 64'd1);
        send(16'd1, 16'd1, 17'd4);
        send(16'd1, 16'd1, 17'd0);
        in_a = 16'd1; in_b = 16'd1; in_approx = 17'd9;
        in_valid = 1'b1;
        clear = 1'b1;
        step();
        in_valid = 1'b0;
        clear = 1'b0;
        step(); step(); step();
        check_stats("clear_flush", 32'd0, 32'd0, 48'd0, 17'd0, 1'b0);
        request_report("clear_rpt");
        check_stats("clear_rpt", 32'd0, 32'd0, 48'd0, 17'd0, 1'b0);
        finish_report("clear_rpt");

        // Saturation on the CNT_W=2 build: 5 samples each with error +1
        for (int i = 0; i < 5; i++) send(16'd1, 16'd1, 17'd3);
        request_report("satur");
        check_stats("satur_main", 32'd5, 32'd5, 48'd5, 17'd1, 1'b0);
        check_eq("satur_small_rpt_valid", 64'(s_rpt_valid), 64'd1);
        check_eq("satur_small_sample_cnt", 64'(s_sample_cnt), 64'd3);
        check_eq("satur_small_err_cnt", 64'(s_err_cnt), 64'd3);
        check_eq("satur_small_sq_err_sum", 64'(s_sq_err_sum), 64'd5);
        check_eq("satur_small_sat", 64'(s_sat), 64'd1);
        finish_report("satur");
        step(); step();
        check_eq("satur_sticky", 64'(s_sat), 64'd1);
        pulse_clear();
        check_eq("satur_cleared", 64'(s_sat), 64'd0);
        check_eq("satur_cleared_cnt", 64'(s_sample_cnt), 64'd0);

        // Reset while in REPORT
        send(16'd2, 16'd2, 17'd7);
        request_report("rst_rpt");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_rpt_rpt_valid", 64'(rpt_valid), 64'd0);
        check_eq("rst_rpt_in_ready", 64'(in_ready), 64'd1);
        check_stats("rst_rpt", 32'd0, 32'd0, 48'd0, 17'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
